// File: rtl/conv_pkg.sv
// Shared types and helpers for the conv / pooling stages.
// Latency: n/a (package only).
// Backpressure: n/a.
package conv_pkg;

  // Default sample width, matching the conv stage output.
  localparam int W_DEFAULT = 20;

  // Working width of the signed-max helper; callers sign-extend into it.
  localparam int SMAX_W = 64;

  // Pooling FSM: inside a full window, or consuming the short frame tail.
  typedef enum logic [0:0] {
    S_ACC  = 1'b0,
    S_DROP = 1'b1
  } pool_state_e;

  // Signed maximum of two sign-extended samples.
  function automatic logic signed [SMAX_W-1:0] smax(
    input logic signed [SMAX_W-1:0] a,
    input logic signed [SMAX_W-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/maxpool_fifo2.sv
// Two-entry output FIFO with a registered head and an occupancy count.
// Latency: a push into an empty FIFO is visible at the head after 1 edge.
// Backpressure: a push while full is dropped unless a pop happens in the same cycle.
module maxpool_fifo2
  import conv_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic [1:0]   count_q, count_d;
  logic         do_pop;
  logic         do_push;

  // Next state: a simultaneous push and pop keeps occupancy and order.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    do_pop  = pop_i && (count_q != 2'd0);
    do_push = push_i && ((count_q != 2'd2) || do_pop);
    case ({do_push, do_pop})
      2'b10: begin
        if (count_q == 2'd0) begin
          head_d = din_i;
        end else begin
          tail_d = din_i;
        end
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        // The head is left stale when the FIFO drains; y_valid masks it.
        if (count_q == 2'd2) begin
          head_d = tail_q;
        end
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        if (count_q == 2'd1) begin
          head_d = din_i;
        end else begin
          head_d = tail_q;
          tail_d = din_i;
        end
      end
      default: begin
      end
    endcase
  end

  // Storage and occupancy, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_o  = head_q;
  assign count_o = count_q;

endmodule

// File: rtl/maxpool_stream.sv
// Streaming 1-D max pooling: window/stride P over frames of N signed samples.
// Latency: 1 cycle from the window-completing input to y_valid (FIFO empty).
// Backpressure: x_ready drops only when a window would complete into a full 2-entry FIFO.
module maxpool_stream
  import conv_pkg::*;
#(
  parameter int W = W_DEFAULT,
  parameter int N = 9,
  parameter int P = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic signed [W-1:0] x_data,
  input  logic                x_valid,
  output logic                x_ready,
  output logic signed [W-1:0] y_data,
  output logic                y_valid,
  input  logic                y_ready
);

  localparam int PCW          = (P > 1) ? $clog2(P) : 1;
  localparam int FCW          = (N > 1) ? $clog2(N) : 1;
  localparam int TAIL         = N % P;
  localparam int LAST_WIN_END = (N / P) * P - 1;

  localparam logic [PCW-1:0] P_LAST    = PCW'(P - 1);
  localparam logic [FCW-1:0] F_LAST    = FCW'(N - 1);
  localparam logic [FCW-1:0] F_WIN_END = FCW'(LAST_WIN_END);

  pool_state_e        state_q;
  logic [PCW-1:0]     pcnt_q, pcnt_d;
  logic [FCW-1:0]     fcnt_q, fcnt_d;
  logic signed [W-1:0] max_q, max_d;
  logic signed [W-1:0] win_max;
  logic [W-1:0]       fifo_head;
  logic [1:0]         fifo_cnt;
  logic               accept;
  logic               at_win_end;
  logic               frame_last;
  logic               push;
  logic               pop;

  // Handshake and position decode; x_ready looks only at registered state.
  assign at_win_end = (state_q == S_ACC) && (pcnt_q == P_LAST);
  assign frame_last = (fcnt_q == F_LAST);
  assign x_ready    = !(at_win_end && (fifo_cnt == 2'd2));
  assign accept     = x_valid && x_ready;
  assign push       = accept && at_win_end;
  assign pop        = y_valid && y_ready;

  // First sample of a window loads directly; later ones fold in by signed max.
  // With P==1 pcnt is always zero, so the window max is the sample itself.
  assign win_max = (pcnt_q == '0) ? x_data
                                  : W'(smax(SMAX_W'(max_q), SMAX_W'(x_data)));

  // Counters and running max advance only on an accepted sample.
  always_comb begin
    pcnt_d = pcnt_q;
    fcnt_d = fcnt_q;
    max_d  = max_q;
    if (accept) begin
      max_d = win_max;
      if (frame_last) begin
        pcnt_d = '0;
        fcnt_d = '0;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
        pcnt_d = (pcnt_q == P_LAST) ? '0 : pcnt_q + 1'b1;
      end
    end
  end

  // Frame FSM: drop the short tail after the last full window of a frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_ACC;
    end else if (accept) begin
      case (state_q)
        S_ACC: begin
          if ((TAIL != 0) && (pcnt_q == P_LAST) && (fcnt_q == F_WIN_END)) begin
            state_q <= S_DROP;
          end
        end
        S_DROP: begin
          if (frame_last) begin
            state_q <= S_ACC;
          end
        end
        default: state_q <= S_ACC;
      endcase
    end
  end

  // Datapath registers; a reset mid-frame discards the partial window.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcnt_q <= '0;
      fcnt_q <= '0;
      max_q  <= '0;
    end else begin
      pcnt_q <= pcnt_d;
      fcnt_q <= fcnt_d;
      max_q  <= max_d;
    end
  end

  maxpool_fifo2 #(
    .W(W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .din_i   (win_max),
    .pop_i   (pop),
    .head_o  (fifo_head),
    .count_o (fifo_cnt)
  );

  assign y_data  = fifo_head;
  assign y_valid = (fifo_cnt != 2'd0);

endmodule

// File: tb/tb_maxpool_stream.sv
module tb_maxpool_stream;

  localparam int W = 20;

  logic clk = 1'b0;
  logic reset;

  logic signed [W-1:0] x_data, y_data;
  logic x_valid, x_ready, y_valid, y_ready;

  logic signed [W-1:0] x8_data, y8_data;
  logic x8_valid, x8_ready, y8_valid, y8_ready;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  maxpool_stream dut (
    .clk(clk), .reset(reset),
    .x_data(x_data), .x_valid(x_valid), .x_ready(x_ready),
    .y_data(y_data), .y_valid(y_valid), .y_ready(y_ready)
  );

  maxpool_stream #(.W(20), .N(8), .P(3)) dut8 (
    .clk(clk), .reset(reset),
    .x_data(x8_data), .x_valid(x8_valid), .x_ready(x8_ready),
    .y_data(y8_data), .y_valid(y8_valid), .y_ready(y8_ready)
  );

  typedef struct {
    logic signed [W-1:0] x;
    logic                exp_vld;
    logic signed [W-1:0] exp_y;
  } vec_t;

  vec_t vt[27];
  vec_t vt8[11];

  task automatic check(input string nm, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic setv(input int i, input int x, input bit v, input int y);
    vt[i].x = W'(x); vt[i].exp_vld = v; vt[i].exp_y = W'(y);
  endtask

  task automatic setv8(input int i, input int x, input bit v, input int y);
    vt8[i].x = W'(x); vt8[i].exp_vld = v; vt8[i].exp_y = W'(y);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic signed [W-1:0] got_q[$];
    logic signed [W-1:0] exp_q[$];
    logic signed [63:0]  v;
    int  bp_exp[3];
    int  m_f, m_acc, cyc, mism, indep_err, s;
    logic signed [W-1:0] m_max;
    logic acc, popd, r0, r1;
    logic signed [W-1:0] pdat;

    // Table: REQ-style frames for the default instance (one sample per cycle).
    setv(0, 5, 0, 0);   setv(1, -3, 0, 0);  setv(2, 7, 1, 7);
    setv(3, 0, 0, 0);   setv(4, 0, 0, 0);   setv(5, 0, 1, 0);
    setv(6, -8, 0, 0);  setv(7, -2, 0, 0);  setv(8, -9, 1, -2);
    for (int i = 9; i < 18; i++) setv(i, -524288, ((i % 3) == 2), -524288);
    setv(18, -1, 0, 0); setv(19, -5, 0, 0); setv(20, -2, 1, -1);
    setv(21, 524287, 0, 0); setv(22, 0, 0, 0); setv(23, -524288, 1, 524287);
    setv(24, 4, 0, 0);  setv(25, 4, 0, 0);  setv(26, 4, 1, 4);

    // Table: N=8, P=3 instance, tail of two samples then a fresh frame.
    for (int i = 0; i < 8; i++) setv8(i, i + 1, (i == 2) || (i == 5), (i == 2) ? 3 : 6);
    setv8(8, -5, 0, 0); setv8(9, 9, 0, 0); setv8(10, 2, 1, 9);

    reset = 1'b0; x_data = '0; x_valid = 1'b0; y_ready = 1'b0;
    x8_data = '0; x8_valid = 1'b0; y8_ready = 1'b1;

    // Reset state
    #2;
    check("rst_yvld", y_valid, 0);
    check("rst_ydat", y_data, 0);
    check("rst_xrdy", x_ready, 1);
    check("rst8_xrdy", x8_ready, 1);
    @(posedge clk); @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    // Back-to-back frames, y_ready high
    y_ready = 1'b1;
    for (int i = 0; i < 27; i++) begin
      x_data = vt[i].x; x_valid = 1'b1;
      check("tbl_xrdy", x_ready, 1);
      @(posedge clk); #1;
      check("tbl_yvld", y_valid, vt[i].exp_vld);
      if (vt[i].exp_vld) check("tbl_ydat", y_data, vt[i].exp_y);
    end
    x_valid = 1'b0;

    // Frame tail discard on the N=8 instance
    for (int i = 0; i < 11; i++) begin
      x8_data = vt8[i].x; x8_valid = 1'b1;
      check("n8_xrdy", x8_ready, 1);
      @(posedge clk); #1;
      check("n8_yvld", y8_valid, vt8[i].exp_vld);
      if (vt8[i].exp_vld) check("n8_ydat", y8_data, vt8[i].exp_y);
    end
    x8_valid = 1'b0;
    @(posedge clk); #1;

    // Backpressure: two outputs buffered, third completing sample stalls
    y_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      x_data = vt[i].x; x_valid = 1'b1;
      check("bp_xrdy_open", x_ready, 1);
      @(posedge clk); #1;
    end
    x_data = vt[8].x;
    for (int c = 0; c < 3; c++) begin
      check("bp_xrdy_stall", x_ready, 0);
      @(posedge clk); #1;
    end
    check("bp_head", y_data, 7);
    y_ready = 1'b1;
    got_q.delete();
    for (int c = 0; c < 20 && got_q.size() < 3; c++) begin
      if (y_valid) got_q.push_back(y_data);
      acc = x_valid && x_ready;
      @(posedge clk); #1;
      if (acc) x_valid = 1'b0;
    end
    x_valid = 1'b0;
    bp_exp[0] = 7; bp_exp[1] = 0; bp_exp[2] = -2;
    check("bp_count", got_q.size(), 3);
    for (int k = 0; k < 3; k++) begin
      v = 'x;
      if (k < got_q.size()) v = got_q[k];
      check("bp_order", v, bp_exp[k]);
    end
    @(posedge clk); #1;

    // Asynchronous reset mid-frame with an output buffered
    y_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      x_data = (i < 3) ? W'(i + 1) : ((i == 3) ? W'(5) : W'(100));
      x_valid = 1'b1;
      @(posedge clk); #1;
    end
    x_valid = 1'b0;
    check("mid_yvld_pre", y_valid, 1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_yvld", y_valid, 0);
    check("mid_rst_ydat", y_data, 0);
    check("mid_rst_xrdy", x_ready, 1);
    @(negedge clk); reset = 1'b1; y_ready = 1'b1;
    @(posedge clk); #1;
    x_data = -20'sd1; x_valid = 1'b1;
    @(posedge clk); #1;
    check("post_rst_yvld0", y_valid, 0);
    x_data = -20'sd4;
    @(posedge clk); #1;
    x_data = -20'sd2;
    @(posedge clk); #1;
    x_valid = 1'b0;
    check("post_rst_yvld", y_valid, 1);
    check("post_rst_ydat", y_data, -1);
    @(posedge clk); #1;

    // Random handshakes against a reference model
    #2 reset = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    got_q.delete(); exp_q.delete();
    m_f = 0; m_acc = 0; m_max = '0; indep_err = 0;
    for (cyc = 0; cyc < 60000 && m_acc < 9000; cyc++) begin
      x_valid = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: x_data = -20'sd524288;
        1: x_data = 20'sd524287;
        2: begin s = $urandom_range(0, 20); x_data = W'(s - 10); end
        default: x_data = W'($urandom);
      endcase
      y_ready = 1'b0; #1; r0 = x_ready;
      y_ready = 1'b1; #1; r1 = x_ready;
      if (r0 !== r1) indep_err++;
      y_ready = 1'($urandom_range(0, 1)); #1;
      acc = x_valid && x_ready;
      popd = y_valid && y_ready;
      pdat = y_data;
      @(posedge clk); #1;
      if (popd) got_q.push_back(pdat);
      if (acc) begin
        if ((m_f % 3) == 0) m_max = x_data;
        else if (x_data > m_max) m_max = x_data;
        if ((m_f % 3) == 2) exp_q.push_back(m_max);
        m_f = (m_f == 8) ? 0 : m_f + 1;
        m_acc++;
      end
    end
    x_valid = 1'b0; y_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      #3;
      popd = y_valid && y_ready; pdat = y_data;
      @(posedge clk); #1;
      if (popd) got_q.push_back(pdat);
    end
    check("rnd_budget", (m_acc >= 9000), 1);
    check("rnd_xrdy_indep", indep_err, 0);
    check("rnd_count", got_q.size(), exp_q.size());
    mism = 0;
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k >= got_q.size() || got_q[k] !== exp_q[k]) mism++;
    end
    check("rnd_data_mismatches", mism, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
